// File: rtl/link_bist_pkg.sv
// Shared types and PRBS7 helper for the link BIST engine.
package link_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } bist_state_t;

    localparam int unsigned PRBS_W = 7;

    // Next PRBS7 bit from a 7-bit history whose bit 0 is the newest sample.
    function automatic logic prbs7_bit(input logic [PRBS_W-1:0] hist);
        return hist[5] ^ hist[6];
    endfunction

endpackage

// File: rtl/link_bist_lane.sv
// One lane of the link BIST: PRBS7 generator, self-synchronising checker and lock tracking.
module link_bist_lane
    import link_bist_pkg::*;
#(
    parameter int unsigned LOCK_RUN = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_run,
    input  logic              run,
    input  logic              last,
    input  logic [PRBS_W-1:0] seed,
    input  logic              rx,
    output logic              tx,
    output logic              lane_locked,
    output logic              lane_lock_next,
    output logic              lane_err
);

    localparam int unsigned CNT_W = $clog2(LOCK_RUN + 1);

    logic [PRBS_W-1:0] g_q, g_d;
    logic [PRBS_W-1:0] h_q, h_d;
    logic              tx_q, tx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lock_q, lock_d;
    logic              pred, match, qual;

    always_comb begin
        g_d    = g_q;
        h_d    = h_q;
        tx_d   = 1'b0;
        cnt_d  = cnt_q;
        lock_d = lock_q;
        pred   = prbs7_bit(h_q);
        match  = (rx == pred);
        // An all-zero history predicts zero forever; an idle line must not count toward lock.
        qual   = match && (h_q != '0);
        if (start_run) begin
            tx_d   = prbs7_bit(seed);
            g_d    = {seed[PRBS_W-2:0], tx_d};
            h_d    = '0;
            cnt_d  = '0;
            lock_d = 1'b0;
        end else if (run) begin
            if (!last) begin
                tx_d = prbs7_bit(g_q);
                g_d  = {g_q[PRBS_W-2:0], tx_d};
            end
            h_d = {h_q[PRBS_W-2:0], rx};
            if (!match) begin
                cnt_d = '0;
            end else if (qual && (cnt_q != CNT_W'(LOCK_RUN))) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CNT_W'(LOCK_RUN)) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            g_q    <= '0;
            h_q    <= '0;
            tx_q   <= 1'b0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            g_q    <= g_d;
            h_q    <= h_d;
            tx_q   <= tx_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign tx             = tx_q;
    assign lane_locked    = lock_q;
    assign lane_lock_next = lock_d;
    assign lane_err       = run && lock_q && !match;

endmodule

// File: rtl/link_bist.sv
// Link BIST top: test-window FSM, per-lane engines, error accumulation and lock latency capture.
module link_bist
    import link_bist_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned LOCK_RUN  = 16,
    parameter int unsigned MAX_LAT   = 15,
    parameter int unsigned ERR_W     = 16,
    localparam int unsigned LC_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LANES-1:0] rx_lanes,
    output logic [LANES-1:0] tx_lanes,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             pass,
    output logic [LANES-1:0] err_lanes,
    output logic [ERR_W-1:0] err_count,
    output logic [LC_W-1:0]  lock_cycles
);

    localparam int unsigned PC_W  = $clog2(LANES + 1);
    localparam int unsigned SUM_W = ERR_W + PC_W;

    if (FRAME_LEN <= MAX_LAT + LOCK_RUN + 8) begin : g_bad_cfg
        $error("link_bist: FRAME_LEN too short for MAX_LAT and LOCK_RUN");
    end

    bist_state_t      state_q, state_d;
    logic [LC_W-1:0]  cnt_q, cnt_d;
    logic [LC_W-1:0]  lock_cycles_q, lock_cycles_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [LANES-1:0] err_lanes_q, err_lanes_d;
    logic [LANES-1:0] tx_vec, lane_lock, lane_lock_next, lane_err;
    logic             start_run, run, last, all_locked;
    logic [PC_W-1:0]  pop;
    logic [SUM_W-1:0] sum;

    assign run        = (state_q == StSend);
    assign last       = run && (cnt_q == LC_W'(FRAME_LEN - 1));
    assign start_run  = start && !run;
    assign all_locked = &lane_lock;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        link_bist_lane #(
            .LOCK_RUN(LOCK_RUN)
        ) u_lane (
            .clock          (clock),
            .reset          (reset),
            .start_run      (start_run),
            .run            (run),
            .last           (last),
            .seed           (PRBS_W'(i + 1)),
            .rx             (rx_lanes[i]),
            .tx             (tx_vec[i]),
            .lane_locked    (lane_lock[i]),
            .lane_lock_next (lane_lock_next[i]),
            .lane_err       (lane_err[i])
        );
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lock_cycles_d = lock_cycles_q;
        err_count_d   = err_count_q;
        err_lanes_d   = err_lanes_q;
        pop           = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            pop = pop + PC_W'(lane_err[i]);
        end
        sum = SUM_W'(err_count_q) + SUM_W'(pop);
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d       = StSend;
                    cnt_d         = '0;
                    lock_cycles_d = '1;
                    err_count_d   = '0;
                    err_lanes_d   = '0;
                end
            end
            StSend: begin
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = StDone;
                end
                // Capture on the edge the last lane locks, so it lines up with locked rising.
                if (!all_locked && (&lane_lock_next)) begin
                    lock_cycles_d = cnt_q + 1'b1;
                end
                err_lanes_d = err_lanes_q | lane_err;
                err_count_d = (|sum[SUM_W-1:ERR_W]) ? '1 : sum[ERR_W-1:0];
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            lock_cycles_q <= '1;
            err_count_q   <= '0;
            err_lanes_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lock_cycles_q <= lock_cycles_d;
            err_count_q   <= err_count_d;
            err_lanes_q   <= err_lanes_d;
        end
    end

    assign tx_lanes    = tx_vec;
    assign busy        = run;
    assign done        = (state_q == StDone);
    assign locked      = all_locked;
    assign pass        = done && all_locked && (err_count_q == '0);
    assign err_lanes   = err_lanes_q;
    assign err_count   = err_count_q;
    assign lock_cycles = lock_cycles_q;

endmodule

// File: tb/tb_link_bist.sv
// Directed bench for link_bist: loopback, delayed loop, bit flip, dead line, stuck lane, reset abort.
module tb_link_bist;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  rx_lanes;
    logic [3:0]  tx_lanes, tx2;
    logic        busy, done, locked, pass;
    logic        busy2, done2, locked2, pass2;
    logic [3:0]  err_lanes, err_lanes2;
    logic [15:0] err_count;
    logic [3:0]  err_count2;
    logic [8:0]  lock_cycles, lock_cycles2;

    int          vectors = 0;
    int          miscompares = 0;
    int          rx_mode;
    logic        stuck_on;
    logic [3:0]  flip_mask;
    logic [3:0]  dly [5];
    logic [3:0]  base;
    int          lc0;

    link_bist dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rx_lanes    (rx_lanes),
        .tx_lanes    (tx_lanes),
        .busy        (busy),
        .done        (done),
        .locked      (locked),
        .pass        (pass),
        .err_lanes   (err_lanes),
        .err_count   (err_count),
        .lock_cycles (lock_cycles)
    );

    link_bist #(
        .ERR_W(4)
    ) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rx_lanes    (rx_lanes),
        .tx_lanes    (tx2),
        .busy        (busy2),
        .done        (done2),
        .locked      (locked2),
        .pass        (pass2),
        .err_lanes   (err_lanes2),
        .err_count   (err_count2),
        .lock_cycles (lock_cycles2)
    );

    always #5 clock = ~clock;

    // 5-cycle loop delay line: rx in cycle c is tx from cycle c-5.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) dly[i] <= 4'b0;
        end else begin
            dly[0] <= tx_lanes;
            for (int i = 1; i < 5; i++) dly[i] <= dly[i-1];
        end
    end

    always_comb begin
        base = tx_lanes;
        case (rx_mode)
            0: base = tx_lanes;
            1: base = dly[4];
            2: base = 4'b0;
            default: base = stuck_on ? {1'b1, tx_lanes[2:0]} : tx_lanes;
        endcase
        rx_lanes = base ^ flip_mask;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int g = 0; g < 400 && !done; g++) begin
            if (busy) nbusy++;
            step();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done: done=%b after 400 cycles, required 1", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_mode = 0; stuck_on = 1'b0; flip_mask = 4'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        vectors++;
        if ({busy, done, locked, pass, err_lanes, err_count, lock_cycles, tx_lanes} !==
            {4'b0, 4'b0, 16'd0, 9'h1FF, 4'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got b%b d%b l%b p%b el=%h ec=%h lc=%h tx=%h, want all 0 lc=1ff",
                     busy, done, locked, pass, err_lanes, err_count, lock_cycles, tx_lanes);
        end
    endtask

    task automatic test_loopback();
        int n;
        rx_mode = 0;
        pulse_start();
        wait_done(n);
        vectors++;
        if (n != 256) begin
            miscompares++; $display("FAIL loop_busy_len: got %0d want 256", n);
        end
        vectors++;
        if ({locked, pass, err_lanes, err_count} !== {1'b1, 1'b1, 4'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL loop_result: got l%b p%b el=%h ec=%0d want l1 p1 el=0 ec=0",
                     locked, pass, err_lanes, err_count);
        end
        vectors++;
        if (lock_cycles !== 9'd23) begin
            miscompares++; $display("FAIL loop_lock_cycles: got %0d want 23", lock_cycles);
        end
        lc0 = int'(lock_cycles);
    endtask

    task automatic test_delay();
        int n;
        rx_mode = 1;
        pulse_start();
        repeat (10) step();
        start = 1'b1;  // ignored while sending
        step();
        start = 1'b0;
        wait_done(n);
        vectors++;
        if (n != 245) begin
            miscompares++; $display("FAIL delay_busy_len: got %0d want 245", n);
        end
        vectors++;
        if (int'(lock_cycles) != lc0 + 5 || lock_cycles !== 9'd28) begin
            miscompares++; $display("FAIL delay_lock_cycles: got %0d want %0d", lock_cycles, lc0 + 5);
        end
        vectors++;
        if (pass !== 1'b1) begin
            miscompares++; $display("FAIL delay_pass: got %b want 1", pass);
        end
    endtask

    task automatic test_bit_flip();
        int n;
        rx_mode = 0;
        pulse_start();
        repeat (100) step();
        flip_mask = 4'b0100;
        step();
        flip_mask = 4'b0;
        wait_done(n);
        vectors++;
        if (err_count !== 16'd3) begin
            miscompares++; $display("FAIL flip_err_count: got %0d want 3", err_count);
        end
        vectors++;
        if ({err_lanes, pass, locked} !== {4'b0100, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flip_flags: got el=%b p%b l%b want el=0100 p0 l1", err_lanes, pass, locked);
        end
    endtask

    task automatic test_zero_rx();
        rx_mode = 2;
        pulse_start();
        vectors++;
        if ({err_count, err_lanes, locked, lock_cycles} !== {16'd0, 4'b0, 1'b0, 9'h1FF}) begin
            miscompares++;
            $display("FAIL restart_clear: got ec=%0d el=%b l%b lc=%h want 0 0 0 1ff",
                     err_count, err_lanes, locked, lock_cycles);
        end
        repeat (255) step();
        start = 1'b1;  // coincides with the last SEND cycle
        step();
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++; $display("FAIL zero_end: got busy=%b done=%b want 0 1", busy, done);
        end
        step();
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++; $display("FAIL last_cycle_start: got busy=%b done=%b want 0 1", busy, done);
        end
        vectors++;
        if ({locked, lock_cycles, err_count, pass} !== {1'b0, 9'h1FF, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL zero_result: got l%b lc=%h ec=%0d p%b want l0 lc=1ff ec=0 p0",
                     locked, lock_cycles, err_count, pass);
        end
    endtask

    task automatic test_stuck_lane();
        int n;
        rx_mode = 3;
        stuck_on = 1'b0;
        pulse_start();
        for (int g = 0; g < 300 && !locked; g++) step();
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++; $display("FAIL stuck_lock_wait: locked=%b want 1", locked);
        end
        stuck_on = 1'b1;
        wait_done(n);
        stuck_on = 1'b0;
        vectors++;
        if (err_count2 !== 4'hF) begin
            miscompares++; $display("FAIL stuck_saturate: got %h want f", err_count2);
        end
        vectors++;
        if (err_count <= 16'd15) begin
            miscompares++; $display("FAIL stuck_err_count: got %0d want > 15", err_count);
        end
        vectors++;
        if ({err_lanes, err_lanes2, pass} !== {4'b1000, 4'b1000, 1'b0}) begin
            miscompares++;
            $display("FAIL stuck_lanes: got el=%b el_sat=%b p%b want 1000 1000 p0",
                     err_lanes, err_lanes2, pass);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        rx_mode = 0;
        pulse_start();
        repeat (50) step();
        reset = 1'b1;
        step();
        vectors++;
        if ({busy, done, locked, pass, err_lanes, err_count, lock_cycles, tx_lanes} !==
            {4'b0, 4'b0, 16'd0, 9'h1FF, 4'b0}) begin
            miscompares++;
            $display("FAIL abort_state: got b%b d%b l%b p%b el=%h ec=%h lc=%h tx=%h, want all 0 lc=1ff",
                     busy, done, locked, pass, err_lanes, err_count, lock_cycles, tx_lanes);
        end
        reset = 1'b0;
        step();
        pulse_start();
        wait_done(n);
        vectors++;
        if (n != 256 || pass !== 1'b1 || lock_cycles !== 9'd23) begin
            miscompares++;
            $display("FAIL abort_rerun: got busy_len=%0d p%b lc=%0d want 256 1 23", n, pass, lock_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_delay();
        test_bit_flip();
        test_zero_rx();
        test_stuck_lane();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
